// File: rtl/pd_pkg.sv
// Shared constants and helpers for the decode/operand-fetch pipeline slice.
package pd_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t X0 = '0;

    function automatic logic idx_hit(input logic en, input reg_idx_t a, input reg_idx_t b);
        return en && (a == b);
    endfunction

endpackage

// File: rtl/of_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, two clear ports, one set port
// and three combinational read taps.
module of_scoreboard
    import pd_pkg::*;
(
    input  logic     clock,
    input  logic     reset_n,
    input  logic     clr_a_en,
    input  reg_idx_t clr_a_idx,
    input  logic     clr_b_en,
    input  reg_idx_t clr_b_idx,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  reg_idx_t tap_rs1,
    input  reg_idx_t tap_rs2,
    input  reg_idx_t tap_rd,
    output logic     busy_rs1,
    output logic     busy_rs2,
    output logic     busy_rd
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // Clears are applied before the set so a same-index set wins; x0 can never become busy.
    always_comb begin
        busy_next = busy;
        if (clr_a_en) busy_next[clr_a_idx] = 1'b0;
        if (clr_b_en) busy_next[clr_b_idx] = 1'b0;
        if (set_en && set_idx != X0) busy_next[set_idx] = 1'b1;
        busy_next[X0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) busy <= '0;
        else          busy <= busy_next;
    end

    assign busy_rs1 = busy[tap_rs1];
    assign busy_rs2 = busy[tap_rs2];
    assign busy_rd  = busy[tap_rd];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads rs1/rs2, forwards same-cycle writeback, interlocks RAW/WAW via the
// scoreboard and holds the result in a one-entry valid/ready output slot.
module operand_fetch
    import pd_pkg::reg_idx_t, pd_pkg::X0, pd_pkg::idx_hit;
#(
    parameter int XLEN   = pd_pkg::XLEN,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  reg_idx_t        in_rs1,
    input  reg_idx_t        in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  reg_idx_t        in_rd,
    input  logic            in_rd_we,
    output reg_idx_t        addr_rs1,
    output reg_idx_t        addr_rs2,
    input  logic [XLEN-1:0] data_rs1,
    input  logic [XLEN-1:0] data_rs2,
    input  logic            wb_we,
    input  reg_idx_t        wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            retire_valid,
    input  reg_idx_t        retire_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output reg_idx_t        out_rd,
    output logic            out_rd_we
);

    logic            fwd1, fwd2;
    logic            busy_rs1, busy_rs2, busy_rd;
    logic            haz1, haz2, haz_rd;
    logic            slot_free, capture, kill;
    logic [XLEN-1:0] op1, op2;

    assign addr_rs1 = in_rs1;
    assign addr_rs2 = in_rs2;

    assign fwd1 = BYPASS && idx_hit(wb_we, wb_addr, in_rs1);
    assign fwd2 = BYPASS && idx_hit(wb_we, wb_addr, in_rs2);

    // Forwarded writeback both supplies the operand and lifts the RAW interlock in the same cycle.
    always_comb begin
        op1 = data_rs1;
        op2 = data_rs2;
        if (in_rs1 == X0) op1 = '0;
        else if (fwd1)    op1 = wb_data;
        if (in_rs2 == X0) op2 = '0;
        else if (fwd2)    op2 = wb_data;
    end

    assign haz1   = in_use_rs1 && (in_rs1 != X0) && busy_rs1 && !fwd1;
    assign haz2   = in_use_rs2 && (in_rs2 != X0) && busy_rs2 && !fwd2;
    assign haz_rd = in_rd_we && (in_rd != X0) && busy_rd && !idx_hit(retire_valid, retire_rd, in_rd);

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = reset_n && !flush && slot_free && !haz1 && !haz2 && !haz_rd;
    assign capture   = in_valid && in_ready;
    assign kill      = flush && out_valid;

    of_scoreboard u_scoreboard (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr_a_en  (retire_valid),
        .clr_a_idx (retire_rd),
        .clr_b_en  (kill && out_rd_we),
        .clr_b_idx (out_rd),
        .set_en    (capture && in_rd_we),
        .set_idx   (in_rd),
        .tap_rs1   (in_rs1),
        .tap_rs2   (in_rs2),
        .tap_rd    (in_rd),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
        .busy_rd   (busy_rd)
    );

    // Payload only moves on capture, so a stalled or drained slot keeps its last contents.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_imm     <= in_imm;
            out_rs1_val <= op1;
            out_rs2_val <= op2;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we;
        end else if (kill || out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table plus randomized traffic against
// an abstract model of the scoreboard, output slot and register file.
module tb_operand_fetch;

    logic        clock;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_rs1, in_use_rs2, in_rd_we;
    logic [4:0]  addr_rs1, addr_rs2;
    logic [31:0] data_rs1, data_rs2;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_rd_we;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];
    assign data_rs1 = rf[addr_rs1];
    assign data_rs2 = rf[addr_rs2];

    operand_fetch #(.XLEN(32), .BYPASS(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .data_rs1(data_rs1), .data_rs2(data_rs2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_we(out_rd_we)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n, valid, use1, use2, rd_we, wb_we, ret_v, flush, oready;
        logic [4:0]  rs1, rs2, rd, wb_addr, ret_rd;
        logic [31:0] wb_data;
        logic        exp_ready, exp_valid;
        logic [31:0] exp_v1, exp_v2;
    } vec_t;

    vec_t tbl[$];

    // Abstract model state: busy flags per register and the single output slot.
    bit          busy_m [32];
    logic        m_valid, m_rd_we;
    logic [31:0] m_pc, m_imm, m_v1, m_v2;
    logic [4:0]  m_rd;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic [31:0] pc, input logic [31:0] imm);
        reset_n      = v.rst_n;   in_valid   = v.valid;
        in_rs1       = v.rs1;     in_use_rs1 = v.use1;
        in_rs2       = v.rs2;     in_use_rs2 = v.use2;
        in_rd        = v.rd;      in_rd_we   = v.rd_we;
        in_pc        = pc;        in_imm     = imm;
        wb_we        = v.wb_we;   wb_addr    = v.wb_addr;  wb_data = v.wb_data;
        retire_valid = v.ret_v;   retire_rd  = v.ret_rd;
        flush        = v.flush;   out_ready  = v.oready;
    endtask

    task automatic rfWrite();
        if (wb_we && wb_addr != 5'd0) rf[wb_addr] = wb_data;
    endtask

    function automatic vec_t op(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] rd, input logic we,
                                input logic er, input logic ev, input logic [31:0] e1,
                                input logic [31:0] e2);
        vec_t v;
        v.rst_n = 1'b1; v.valid = 1'b1; v.oready = 1'b1;
        v.rs1 = rs1; v.use1 = u1; v.rs2 = rs2; v.use2 = u2; v.rd = rd; v.rd_we = we;
        v.wb_we = 1'b0; v.wb_addr = '0; v.wb_data = '0;
        v.ret_v = 1'b0; v.ret_rd = '0; v.flush = 1'b0;
        v.exp_ready = er; v.exp_valid = ev; v.exp_v1 = e1; v.exp_v2 = e2;
        return v;
    endfunction

    function automatic logic [31:0] pick(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_we && wb_addr == idx) return wb_data;
        return rf[idx];
    endfunction

    // Readiness from the hazard rules: a source is blocked while busy unless written back now,
    // a destination is blocked while busy unless retiring now.
    function automatic logic modelReady();
        logic h1, h2, hr;
        h1 = in_use_rs1 && in_rs1 != 0 && busy_m[in_rs1] && !(wb_we && wb_addr == in_rs1);
        h2 = in_use_rs2 && in_rs2 != 0 && busy_m[in_rs2] && !(wb_we && wb_addr == in_rs2);
        hr = in_rd_we && in_rd != 0 && busy_m[in_rd] && !(retire_valid && retire_rd == in_rd);
        return reset_n && !flush && (!m_valid || out_ready) && !h1 && !h2 && !hr;
    endfunction

    task automatic modelStep(input logic rdy);
        logic cap;
        cap = in_valid && rdy;
        if (!reset_n) begin
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            m_valid = 0; m_pc = 0; m_imm = 0; m_v1 = 0; m_v2 = 0; m_rd = 0; m_rd_we = 0;
        end else begin
            if (retire_valid) busy_m[retire_rd] = 1'b0;
            if (flush && m_valid && m_rd_we) busy_m[m_rd] = 1'b0;
            if (cap && in_rd_we && in_rd != 0) busy_m[in_rd] = 1'b1;
            if (cap) begin
                m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_rd = in_rd; m_rd_we = in_rd_we;
                m_v1 = pick(in_rs1); m_v2 = pick(in_rs2);
            end else if (out_ready || (flush && m_valid)) begin
                m_valid = 0;
            end
        end
    endtask

    initial begin
        vec_t v;
        foreach (rf[i]) rf[i] = 32'h100 + i;
        rf[0] = 0; rf[5] = 32'd7; rf[6] = 32'd9;

        v = op(5,1,0,0,7,1, 0,0,0,0); v.rst_n = 0; tbl.push_back(v); tbl.push_back(v);
        tbl.push_back(op(5,1,6,1,7,1, 1,1,7,9));
        tbl.push_back(op(7,1,0,0,0,0, 0,0,7,9));
        tbl.push_back(op(0,0,0,0,7,1, 0,0,7,9));
        v = op(0,0,0,0,7,1, 1,1,0,0); v.ret_v = 1; v.ret_rd = 7; tbl.push_back(v);
        tbl.push_back(op(7,1,0,0,0,0, 0,0,0,0));
        v = op(7,1,6,1,0,0, 1,1,32'h1234,9);
        v.wb_we = 1; v.wb_addr = 7; v.wb_data = 32'h1234; v.ret_v = 1; v.ret_rd = 7;
        tbl.push_back(v);
        tbl.push_back(op(7,1,0,0,9,1, 1,1,32'h1234,0));
        for (int i = 0; i < 4; i++) begin
            v = op(5,1,0,0,0,0, 0,1,32'h1234,0); v.oready = 0; tbl.push_back(v);
        end
        tbl.push_back(op(5,1,0,0,0,0, 1,1,7,0));
        v = op(6,1,0,0,9,1, 1,1,9,0); v.ret_v = 1; v.ret_rd = 9; tbl.push_back(v);
        v = op(5,1,0,0,0,0, 0,0,9,0); v.flush = 1; v.oready = 0; tbl.push_back(v);
        tbl.push_back(op(9,1,0,0,0,0, 1,1,32'h109,0));
        tbl.push_back(op(0,1,0,0,0,1, 1,1,0,0));
        tbl.push_back(op(0,1,0,1,0,1, 1,1,0,0));
        v = op(0,0,0,0,0,0, 1,0,0,0); v.valid = 0; tbl.push_back(v);
        v.flush = 1; v.exp_ready = 0; tbl.push_back(v);
        tbl.push_back(op(0,0,0,0,5,1, 1,1,0,0));
        for (int i = 0; i < 3; i++) tbl.push_back(op(5,1,0,0,0,0, 0,0,0,0));
        v = op(5,1,0,0,8,1, 1,1,32'h55,0);
        v.wb_we = 1; v.wb_addr = 5; v.wb_data = 32'h55; v.ret_v = 1; v.ret_rd = 5;
        tbl.push_back(v);
        v = op(0,0,0,0,0,0, 0,0,0,0); v.rst_n = 0; v.valid = 0; tbl.push_back(v);
        tbl.push_back(op(0,0,0,0,8,1, 1,1,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            applyStimulus(tbl[i], 32'h1000 + 32'(i * 4), 32'(i));
            #1;
            checkOutput($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_ready});
            @(posedge clock);
            #1;
            rfWrite();
            checkOutput($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
            checkOutput($sformatf("vec%0d out_rs1_val", i), out_rs1_val, tbl[i].exp_v1);
            checkOutput($sformatf("vec%0d out_rs2_val", i), out_rs2_val, tbl[i].exp_v2);
        end

        // Random traffic over a small register window so hazards are frequent.
        for (int c = 0; c < 3000; c++) begin
            logic rdy;
            @(negedge clock);
            reset_n      = (c < 2) ? 1'b0 : ($urandom_range(0, 99) >= 2);
            in_valid     = ($urandom_range(0, 9) < 7);
            in_pc        = $urandom;
            in_imm       = $urandom;
            in_rs1       = 5'($urandom_range(0, 7));
            in_rs2       = 5'($urandom_range(0, 7));
            in_use_rs1   = $urandom_range(0, 1) == 1;
            in_use_rs2   = $urandom_range(0, 1) == 1;
            in_rd        = 5'($urandom_range(0, 7));
            in_rd_we     = $urandom_range(0, 3) != 0;
            wb_we        = ($urandom_range(0, 9) < 3);
            wb_addr      = 5'($urandom_range(0, 7));
            wb_data      = $urandom;
            retire_valid = ($urandom_range(0, 9) < 3);
            retire_rd    = 5'($urandom_range(0, 7));
            flush        = ($urandom_range(0, 9) == 0);
            out_ready    = ($urandom_range(0, 9) < 7);
            #1;
            rdy = modelReady();
            checkOutput("rnd in_ready", {31'd0, in_ready}, {31'd0, rdy});
            checkOutput("rnd addr_rs", {22'd0, addr_rs2, addr_rs1}, {22'd0, in_rs2, in_rs1});
            @(posedge clock);
            #1;
            modelStep(rdy);
            rfWrite();
            checkOutput("rnd out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            checkOutput("rnd out_pc", out_pc, m_pc);
            checkOutput("rnd out_imm", out_imm, m_imm);
            checkOutput("rnd out_rs1_val", out_rs1_val, m_v1);
            checkOutput("rnd out_rs2_val", out_rs2_val, m_v2);
            checkOutput("rnd out_rd", {26'd0, out_rd_we, out_rd}, {26'd0, m_rd_we, m_rd});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
